// File: rtl/control_sequencer.sv
// control_sequencer: microprogram sequencer with branch, wait and call/return stack.
module control_sequencer #(
    parameter int ADDR_W      = 7,
    parameter int WORD_W      = 45,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stall,
    input  logic [WORD_W-1:0] rom_word,
    input  logic [ADDR_W-1:0] decode_addr,
    input  logic [7:0]        cond,
    output logic [ADDR_W-1:0] index,
    output logic [WORD_W-1:0] cr,
    output logic              busy,
    output logic              fault
);
    localparam int SW = $clog2(STACK_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] upc, nxt, inc, tgt;
    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [2:0] nsel, csel;
    logic [SW:0] sp;
    logic [SW-1:0] top;
    logic c, push, pop, err;
    assign tgt   = rom_word[ADDR_W-1:0];
    assign nsel  = rom_word[ADDR_W+2:ADDR_W];
    assign csel  = rom_word[ADDR_W+5:ADDR_W+3];
    assign c     = cond[csel];
    assign inc   = upc + ADDR_W'(1);
    assign top   = sp[SW-1:0] - SW'(1);
    assign index = upc;
    assign busy  = state == RUN;
    assign fault = state == FAULT;
    always_comb begin
        nxt  = inc;
        push = 1'b0;
        pop  = 1'b0;
        case (nsel)
            3'd1: nxt = tgt;
            3'd2: nxt = decode_addr;
            3'd3: nxt = c ? tgt : inc;
            3'd4: nxt = c ? inc : tgt;
            3'd5: nxt = cond[5] ? inc : upc;
            3'd6: begin
                nxt  = tgt;
                push = 1'b1;
            end
            3'd7: begin
                nxt = stack[top];
                pop = 1'b1;
            end
            default: nxt = inc;
        endcase
        err = (push && sp == (SW+1)'(STACK_DEPTH)) || (pop && sp == '0);
    end
    always_comb begin
        state_nx = state;
        if (!stall)
            case (state)
                IDLE:    state_nx = start ? RUN : IDLE;
                RUN:     state_nx = err ? FAULT : RUN;
                default: state_nx = state;
            endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    // a stack error leaves upc and the stack untouched so index shows the faulting word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            upc <= '0;
            cr  <= '0;
            sp  <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else if (!stall && state == RUN) begin
            if (err) begin
                cr <= '0;
            end else begin
                upc <= nxt;
                cr  <= rom_word;
                if (push) begin
                    stack[sp[SW-1:0]] <= inc;
                    sp <= sp + (SW+1)'(1);
                end
                if (pop) sp <= sp - (SW+1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of sequencing, stack, stall and reset behaviour.
module tb_control_sequencer;
    localparam logic [2:0] INC = 3'd0, JMP = 3'd1, DEC = 3'd2, BR = 3'd3,
                           BRN = 3'd4, WAIT = 3'd5, CALL = 3'd6, RET = 3'd7;
    logic clk, reset_n, start, stall;
    logic [44:0] rom_word, cr;
    logic [6:0] decode_addr, index;
    logic [7:0] cond;
    logic busy, fault;
    logic [44:0] rom [128];
    int total = 0, bad = 0;

    control_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
        .rom_word(rom_word), .decode_addr(decode_addr), .cond(cond),
        .index(index), .cr(cr), .busy(busy), .fault(fault)
    );

    assign rom_word = rom[index];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [44:0] w(input logic [2:0] cs, input logic [2:0] ns,
                                      input logic [6:0] t, input logic [6:0] a);
        return {8'hC5, 17'h0, a, cs, ns, t};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        reset_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        cond = 8'h80;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 128; i++) rom[i] = w(3'd0, INC, 7'd0, 7'(i));
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_br(input logic [2:0] ns, input logic z, input logic [6:0] exp, input string tag);
        restart();
        rom[0] = w(3'd0, JMP, 7'h05, 7'h00);
        rom[5] = w(3'd0, ns, 7'h20, 7'h05);
        cond = {7'h40, z};
        go();
        tick();
        chk({tag, "_at5"}, 64'(index), 64'h05);
        tick();
        chk(tag, 64'(index), 64'(exp));
        chk({tag, "_cr"}, 64'(cr), 64'(rom[5]));
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        cond = 8'h80;
        decode_addr = 7'h45;
        for (int i = 0; i < 128; i++) rom[i] = '0;
        #3;
        chk("rst_index", 64'(index), 64'h0);
        chk("rst_cr", 64'(cr), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_fault", 64'(fault), 64'h0);
        tick();

        // straight-line INC then JMP back to 0
        restart();
        rom[4] = w(3'd0, JMP, 7'h00, 7'h04);
        go();
        chk("start_busy", 64'(busy), 64'h1);
        chk("start_index", 64'(index), 64'h0);
        chk("start_cr", 64'(cr), 64'h0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("seq_index", 64'(index), 64'(k % 5));
            chk("seq_cr", 64'(cr), 64'(rom[k - 1]));
        end
        tick();
        chk("seq_wrap1", 64'(index), 64'h1);
        reset_n = 1'b0;
        #1;
        chk("async_index", 64'(index), 64'h0);
        chk("async_cr", 64'(cr), 64'h0);
        chk("async_busy", 64'(busy), 64'h0);
        #1;
        reset_n = 1'b1;
        tick();

        run_br(BR, 1'b1, 7'h20, "br_z1");
        run_br(BR, 1'b0, 7'h06, "br_z0");
        run_br(BRN, 1'b1, 7'h06, "brn_z1");
        run_br(BRN, 1'b0, 7'h20, "brn_z0");

        // WAIT on memory ready
        restart();
        rom[0] = w(3'd0, JMP, 7'h10, 7'h00);
        rom[16] = w(3'd0, WAIT, 7'h00, 7'h10);
        go();
        tick();
        chk("wait_enter", 64'(index), 64'h10);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wait_hold", 64'(index), 64'h10);
            chk("wait_cr", 64'(cr), 64'(rom[16]));
        end
        cond = 8'hA0;
        tick();
        chk("wait_exit", 64'(index), 64'h11);
        chk("wait_exit_cr", 64'(cr), 64'(rom[16]));

        // DEC then INC wrap at 0x7F
        restart();
        rom[0] = w(3'd0, DEC, 7'h00, 7'h00);
        rom[69] = w(3'd0, JMP, 7'h7F, 7'h45);
        go();
        tick();
        chk("dec", 64'(index), 64'h45);
        tick();
        chk("jmp7f", 64'(index), 64'h7F);
        tick();
        chk("inc_wrap", 64'(index), 64'h00);
        chk("inc_wrap_cr", 64'(cr), 64'(rom[127]));

        // nested CALL 4 deep then 4 RET
        restart();
        rom[0] = w(3'd0, CALL, 7'h30, 7'h00);
        rom[48] = w(3'd0, CALL, 7'h40, 7'h30);
        rom[64] = w(3'd0, CALL, 7'h50, 7'h40);
        rom[80] = w(3'd0, CALL, 7'h60, 7'h50);
        rom[96] = w(3'd0, RET, 7'h00, 7'h60);
        rom[81] = w(3'd0, RET, 7'h00, 7'h51);
        rom[65] = w(3'd0, RET, 7'h00, 7'h41);
        rom[49] = w(3'd0, RET, 7'h00, 7'h31);
        rom[1] = w(3'd0, JMP, 7'h01, 7'h01);
        go();
        begin
            logic [6:0] exp_seq [9];
            exp_seq = '{7'h30, 7'h40, 7'h50, 7'h60, 7'h51, 7'h41, 7'h31, 7'h01, 7'h01};
            for (int k = 0; k < 9; k++) begin
                tick();
                chk("call_ret", 64'(index), 64'(exp_seq[k]));
            end
        end
        chk("call_ret_fault", 64'(fault), 64'h0);
        chk("call_ret_busy", 64'(busy), 64'h1);

        // fifth CALL overflows
        rom[96] = w(3'd0, CALL, 7'h70, 7'h60);
        restart();
        rom[0] = w(3'd0, CALL, 7'h30, 7'h00);
        rom[48] = w(3'd0, CALL, 7'h40, 7'h30);
        rom[64] = w(3'd0, CALL, 7'h50, 7'h40);
        rom[80] = w(3'd0, CALL, 7'h60, 7'h50);
        rom[96] = w(3'd0, CALL, 7'h70, 7'h60);
        go();
        for (int k = 0; k < 4; k++) tick();
        chk("ovf_at60", 64'(index), 64'h60);
        tick();
        chk("ovf_fault", 64'(fault), 64'h1);
        chk("ovf_cr", 64'(cr), 64'h0);
        chk("ovf_index", 64'(index), 64'h60);
        chk("ovf_busy", 64'(busy), 64'h0);
        tick();
        chk("ovf_held", 64'(index), 64'h60);
        chk("ovf_sticky", 64'(fault), 64'h1);

        // RET on empty stack underflows
        restart();
        rom[0] = w(3'd0, RET, 7'h00, 7'h00);
        go();
        tick();
        chk("udf_fault", 64'(fault), 64'h1);
        chk("udf_index", 64'(index), 64'h0);
        chk("udf_cr", 64'(cr), 64'h0);
        reset_n = 1'b0;
        #1;
        chk("udf_rst_fault", 64'(fault), 64'h0);
        #1;
        reset_n = 1'b1;
        tick();

        // stall during start and during CALL
        restart();
        rom[0] = w(3'd0, CALL, 7'h30, 7'h00);
        rom[48] = w(3'd0, RET, 7'h00, 7'h30);
        rom[1] = w(3'd0, RET, 7'h00, 7'h01);
        stall = 1'b1;
        start = 1'b1;
        tick();
        chk("stall_idle_busy", 64'(busy), 64'h0);
        stall = 1'b0;
        tick();
        start = 1'b0;
        chk("stall_start_busy", 64'(busy), 64'h1);
        stall = 1'b1;
        tick();
        chk("stall_call_index", 64'(index), 64'h0);
        chk("stall_call_cr", 64'(cr), 64'h0);
        stall = 1'b0;
        tick();
        chk("call_after_stall", 64'(index), 64'h30);
        tick();
        chk("ret_after_stall", 64'(index), 64'h01);
        chk("ret_no_fault", 64'(fault), 64'h0);
        tick();
        chk("stall_no_push", 64'(fault), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microprogram sequencer for the ARM control unit. It drives the 7-bit index into the microstore, interprets the sequencing fields of the returned 45-bit microinstruction, and computes the next microaddress. The next address comes from increment, jump, opcode decode, conditional branch, memory-wait, or a 4-deep call/return stack. It registers the full microinstruction as the control word that steers the datapath. It sits between the microstore and the datapath: condition flags and memory-ready come in, the control word goes out.

## Interface
- ADDR_W, 7, microaddress width.
- WORD_W, 45, microinstruction width.
- STACK_DEPTH, 4, return-stack entries; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- start  in  1  leave IDLE and begin execution at microaddress 0.
- stall  in  1  freeze upc, cr, stack and state for this cycle.
- rom_word  in  WORD_W  microinstruction read combinationally from the microstore at `index`.
- decode_addr  in  ADDR_W  entry microaddress from the instruction decoder.
- cond  in  8  datapath condition vector: [0]Z [1]N [2]C [3]V [4]cond_pass [5]mem_ready (MOC) [6]irq [7]constant 1.
- index  out  ADDR_W  microaddress to the microstore; equals upc.
- cr  out  WORD_W  registered control word to the datapath.
- busy  out  1  high in RUN.
- fault  out  1  sticky stack overflow/underflow flag.

## Operation
- Sequencing fields of rom_word:
  - target = [6:0]
  - nsel = [9:7]
  - csel = [12:10]
  - Bits [44:13] are datapath control and are not interpreted here.
- c = cond[csel]; inc = upc+1, modulo 2^ADDR_W, so 127 wraps to 0.
- nsel encodings:
  - 000 INC: next = inc.
  - 001 JMP: next = target.
  - 010 DEC: next = decode_addr.
  - 011 BR: next = c ? target : inc.
  - 100 BRN: next = c ? inc : target.
  - 101 WAIT: next = cond[5] ? inc : upc. This repeats the same word, and cr reloads the same value.
  - 110 CALL: push inc, next = target.
  - 111 RET: pop, next = popped address.
- Stack: sp counts 0..STACK_DEPTH.
  - CALL with sp==STACK_DEPTH is overflow.
  - RET with sp==0 is underflow.
  - Either error goes to FAULT; the stack and upc are not modified.
- States:
  - IDLE: upc=0, cr=0. Moves to RUN when start=1.
  - RUN: normal sequencing. Moves to FAULT on a stack error.
  - FAULT: fault=1, cr=0, upc held. Exits only via reset.
- start is ignored outside IDLE.
- stall=1 holds everything in every state, including the IDLE→RUN transition.

## Timing
- Reset values: index=0, cr=0, busy=0, fault=0, sp=0, state=IDLE, stack contents 0.
- The microstore is combinational. rom_word at cycle t belongs to index(t).
- On each unstalled RUN edge: upc←next and cr←rom_word. The control word for address A reaches the datapath one cycle after A is presented on index.
- Conditions are sampled in the cycle in which the branching word is on rom_word. They reflect the effect of the previous cr.
- Start-up: start high at edge e0 puts the state in RUN with index=0. The word at address 0 appears on cr after edge e0+1.
- Error edge: state←FAULT, cr←0, fault←1. index keeps the faulting address.
- Reset mid-operation immediately forces the reset values, asynchronously. The stack is cleared.
- Simultaneous events:
  - stall dominates WAIT, BR and CALL/RET.
  - A CALL whose target equals inc still pushes.

## Test plan
- Reset then start, with ROM words 0..3 = INC and word 4 = JMP 0x00 → index sequence 0,1,2,3,4,0. cr equals each word one cycle later. busy=1 after start.
- BR csel=0 target=0x20 at address 5 → with Z=1, next index 0x20. With Z=0, next index 6. Repeat with BRN: results are inverted.
- WAIT at address 0x10, with cond[5] low for 3 cycles then high → index stays 0x10 for 4 cycles, then 0x11. cr holds the WAIT word throughout.
- DEC with decode_addr=0x45 → next index 0x45. INC at 0x7F → next index 0x00.
- Nested CALL 4 deep (targets 0x30, 0x40, 0x50, 0x60) then 4×RET → returns to each caller+1 in reverse order. A 5th CALL → fault=1, cr=0, index held. Separately, a RET with an empty stack → fault.
- stall asserted during a CALL cycle and during the IDLE start → no push, no state change. Assert reset_n low mid-RUN → outputs go to their reset values before the next clock edge.
